// File: rtl/cpu_sram_bridge.sv
// CPU byte-bus responder backed by a 16-bit async SRAM with programmable wait states.
// A one-word read buffer lets repeated reads of the same word complete without stalling.
module cpu_sram_bridge #(
    parameter int WAIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        we,
    input  logic [7:0]  out,
    output logic [7:0]  in,
    output logic        ce,
    output logic [18:0] sram_a,
    input  logic [15:0] sram_di,
    output logic [15:0] sram_do,
    output logic        sram_oe,
    output logic        sram_we,
    output logic        sram_ub,
    output logic        sram_lb
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] buf_q;
    logic [18:0] tag_q;
    logic        valid_q;
    logic [18:0] sram_a_q;
    logic [15:0] sram_do_q;
    logic        sram_oe_q;
    logic        sram_we_q;
    logic        sram_ub_q;
    logic        sram_lb_q;

    logic [18:0] word_addr;
    logic        hit;
    logic        unused_addr_hi;

    // Only a 1 MiB window is decoded; upper address bits alias.
    assign unused_addr_hi = ^address[31:20];
    assign word_addr      = address[19:1];
    assign hit            = valid_q && (tag_q == word_addr);

    assign ce = ((state_q == IDLE) && hit && !we) || (state_q == DONE);
    assign in = address[0] ? buf_q[15:8] : buf_q[7:0];

    assign sram_a  = sram_a_q;
    assign sram_do = sram_do_q;
    assign sram_oe = sram_oe_q;
    assign sram_we = sram_we_q;
    assign sram_ub = sram_ub_q;
    assign sram_lb = sram_lb_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            buf_q     <= 16'd0;
            tag_q     <= 19'd0;
            valid_q   <= 1'b0;
            sram_a_q  <= 19'd0;
            sram_do_q <= 16'd0;
            sram_oe_q <= 1'b0;
            sram_we_q <= 1'b0;
            sram_ub_q <= 1'b0;
            sram_lb_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (we) begin
                        sram_a_q  <= word_addr;
                        sram_do_q <= {out, out};
                        sram_ub_q <= address[0];
                        sram_lb_q <= !address[0];
                        sram_we_q <= 1'b1;
                        cnt_q     <= WAIT_CNT;
                        state_q   <= WR;
                        // Write-through keeps the buffered word coherent; misses do not allocate.
                        if (hit) begin
                            if (address[0]) begin
                                buf_q[15:8] <= out;
                            end else begin
                                buf_q[7:0] <= out;
                            end
                        end
                    end else if (!hit) begin
                        sram_a_q  <= word_addr;
                        sram_oe_q <= 1'b1;
                        cnt_q     <= WAIT_CNT;
                        state_q   <= RD;
                    end
                end
                RD: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        buf_q     <= sram_di;
                        tag_q     <= sram_a_q;
                        valid_q   <= 1'b1;
                        sram_oe_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                WR: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        sram_we_q <= 1'b0;
                        sram_ub_q <= 1'b0;
                        sram_lb_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Scoreboard bench for cpu_sram_bridge: three instances (WAIT=1,0,15) exercised one at a time,
// each against a behavioural SRAM and a word-level reference model of memory plus read buffer.
module tb_cpu_sram_bridge;

    localparam int NI = 3;

    typedef struct {
        string       name;
        bit          wr;
        logic [7:0]  data;
        int          stalls;
        int          oe_n;
        int          we_n;
        logic [18:0] sa;
        logic [15:0] sdo;
        bit          ub;
        bit          lb;
    } exp_t;

    logic        clock = 1'b0;
    logic        rst_a  [NI];
    logic [31:0] addr_a [NI];
    logic        we_a   [NI];
    logic [7:0]  out_a  [NI];
    logic [7:0]  in_a   [NI];
    logic        ce_a   [NI];
    logic [18:0] sa_a   [NI];
    logic [15:0] sdi_a  [NI];
    logic [15:0] sdo_a  [NI];
    logic        soe_a  [NI];
    logic        swe_a  [NI];
    logic        sub_a  [NI];
    logic        slb_a  [NI];

    always #5 clock = ~clock;

    cpu_sram_bridge #(.WAIT(1)) u_dut0 (
        .clock(clock), .reset(rst_a[0]), .address(addr_a[0]), .we(we_a[0]), .out(out_a[0]),
        .in(in_a[0]), .ce(ce_a[0]), .sram_a(sa_a[0]), .sram_di(sdi_a[0]), .sram_do(sdo_a[0]),
        .sram_oe(soe_a[0]), .sram_we(swe_a[0]), .sram_ub(sub_a[0]), .sram_lb(slb_a[0]));

    cpu_sram_bridge #(.WAIT(0)) u_dut1 (
        .clock(clock), .reset(rst_a[1]), .address(addr_a[1]), .we(we_a[1]), .out(out_a[1]),
        .in(in_a[1]), .ce(ce_a[1]), .sram_a(sa_a[1]), .sram_di(sdi_a[1]), .sram_do(sdo_a[1]),
        .sram_oe(soe_a[1]), .sram_we(swe_a[1]), .sram_ub(sub_a[1]), .sram_lb(slb_a[1]));

    cpu_sram_bridge #(.WAIT(15)) u_dut2 (
        .clock(clock), .reset(rst_a[2]), .address(addr_a[2]), .we(we_a[2]), .out(out_a[2]),
        .in(in_a[2]), .ce(ce_a[2]), .sram_a(sa_a[2]), .sram_di(sdi_a[2]), .sram_do(sdo_a[2]),
        .sram_oe(soe_a[2]), .sram_we(swe_a[2]), .sram_ub(sub_a[2]), .sram_lb(slb_a[2]));

    int n_cmp = 0;
    int n_bad = 0;
    int act   = 0;

    exp_t        sbq [$];
    exp_t        m_e;
    int          m_stall = 0;
    int          m_oe    = 0;
    int          m_we    = 0;
    bit          m_valid = 1'b0;
    logic [18:0] m_tag   = 19'd0;
    logic [15:0] env_w;

    logic [15:0] smem [bit [20:0]];
    logic [15:0] mmem [bit [20:0]];

    function automatic int waits(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    function automatic logic [15:0] init_word(input logic [18:0] w);
        if (w == 19'h8) return 16'h1234;
        return {w[7:0] ^ 8'hA5, w[7:0] ^ 8'h3C};
    endfunction

    function automatic logic [15:0] env_rd(input int k, input logic [18:0] w);
        bit [20:0] key;
        key = {k[1:0], w};
        if (smem.exists(key)) return smem[key];
        return init_word(w);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp_v, $time);
        end
    endtask

    // Behavioural asynchronous SRAM per instance: lane writes while strobed, data valid while enabled.
    always @(posedge clock) begin
        for (int k = 0; k < NI; k++) begin
            if (swe_a[k]) begin
                env_w = env_rd(k, sa_a[k]);
                if (sub_a[k]) env_w[15:8] = sdo_a[k][15:8];
                if (slb_a[k]) env_w[7:0]  = sdo_a[k][7:0];
                smem[{k[1:0], sa_a[k]}] = env_w;
            end
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < NI; k++) begin
            sdi_a[k] = soe_a[k] ? env_rd(k, sa_a[k]) : 16'h0;
        end
    end

    // Monitor: watches the active instance and retires scoreboard entries when ce acknowledges.
    always @(negedge clock) begin
        if (rst_a[act] || sbq.size() == 0) begin
            m_stall = 0;
            m_oe    = 0;
            m_we    = 0;
        end else begin
            m_e = sbq[0];
            cmp({m_e.name, " oe_we_excl"}, 32'(soe_a[act] && swe_a[act]), 32'd0);
            if (soe_a[act]) begin
                m_oe++;
                cmp({m_e.name, " rd sram_a"}, 32'(sa_a[act]), 32'(m_e.sa));
            end
            if (swe_a[act]) begin
                m_we++;
                cmp({m_e.name, " wr sram_a"}, 32'(sa_a[act]), 32'(m_e.sa));
                cmp({m_e.name, " sram_do"}, 32'(sdo_a[act]), 32'(m_e.sdo));
                cmp({m_e.name, " sram_ub"}, 32'(sub_a[act]), 32'(m_e.ub));
                cmp({m_e.name, " sram_lb"}, 32'(slb_a[act]), 32'(m_e.lb));
            end
            if (ce_a[act]) begin
                cmp({m_e.name, " stalls"}, 32'(m_stall), 32'(m_e.stalls));
                cmp({m_e.name, " oe_cycles"}, 32'(m_oe), 32'(m_e.oe_n));
                cmp({m_e.name, " we_cycles"}, 32'(m_we), 32'(m_e.we_n));
                if (!m_e.wr) cmp({m_e.name, " rdata"}, 32'(in_a[act]), 32'(m_e.data));
                void'(sbq.pop_front());
                m_stall = 0;
                m_oe    = 0;
                m_we    = 0;
            end else begin
                m_stall++;
            end
        end
    end

    // Reference model: byte memory plus "last word fetched by a read miss" buffer.
    task automatic access(input bit w, input logic [31:0] a, input logic [7:0] d, input string nm);
        exp_t        e;
        int          wt;
        logic [18:0] wd;
        bit [20:0]   key;
        logic [15:0] cur;
        bit          h;
        bit          got;
        wt  = waits(act);
        wd  = a[19:1];
        key = {act[1:0], wd};
        cur = mmem.exists(key) ? mmem[key] : init_word(wd);
        e.name = nm;
        e.wr   = w;
        e.sa   = wd;
        e.sdo  = {d, d};
        e.ub   = a[0];
        e.lb   = !a[0];
        if (w) begin
            if (a[0]) cur[15:8] = d;
            else      cur[7:0]  = d;
            mmem[key] = cur;
            e.data   = d;
            e.stalls = wt + 2;
            e.oe_n   = 0;
            e.we_n   = wt + 1;
        end else begin
            h        = m_valid && (m_tag == wd);
            e.data   = a[0] ? cur[15:8] : cur[7:0];
            e.stalls = h ? 0 : wt + 2;
            e.oe_n   = h ? 0 : wt + 1;
            e.we_n   = 0;
            if (!h) begin
                m_valid = 1'b1;
                m_tag   = wd;
            end
        end
        sbq.push_back(e);
        addr_a[act] = a;
        we_a[act]   = w;
        out_a[act]  = d;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clock);
            got = ce_a[act];
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: ce stayed 0 expected 1", nm);
            sbq.delete();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int k);
        act       = k;
        rst_a[k]  = 1'b1;
        addr_a[k] = 32'h0;
        we_a[k]   = 1'b0;
        out_a[k]  = 8'h0;
        m_valid   = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        cmp("reset ce", 32'(ce_a[k]), 32'd0);
        cmp("reset in", 32'(in_a[k]), 32'd0);
        cmp("reset sram_oe", 32'(soe_a[k]), 32'd0);
        cmp("reset sram_we", 32'(swe_a[k]), 32'd0);
        @(posedge clock);
        #1;
        rst_a[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst_a[k]  = 1'b1;
            addr_a[k] = 32'h0;
            we_a[k]   = 1'b0;
            out_a[k]  = 8'h0;
            sdi_a[k]  = 16'h0;
        end
        @(posedge clock);
        #1;

        do_reset(0);
        access(1'b0, 32'h0000_0010, 8'h00, "miss_0x10");
        access(1'b0, 32'h0000_0011, 8'h00, "hit_0x11");
        access(1'b1, 32'h0000_0011, 8'hAB, "wr_0x11");
        access(1'b0, 32'h0000_0011, 8'h00, "hit_after_wr");
        access(1'b1, 32'h0000_0200, 8'h55, "wr_miss_0x200");
        access(1'b0, 32'h0000_0010, 8'h00, "hit_no_alloc");
        access(1'b0, 32'h000F_FFFF, 8'h00, "wrap_hi");
        access(1'b0, 32'h0010_0000, 8'h00, "alias_w0");
        access(1'b0, 32'hABC0_0001, 8'h00, "alias_hit");

        // Reset during the second RD cycle: strobe must drop and nothing is acknowledged.
        addr_a[0] = 32'h0000_0020;
        we_a[0]   = 1'b0;
        repeat (3) @(negedge clock);
        cmp("midrd oe_before", 32'(soe_a[0]), 32'd1);
        cmp("midrd ce_before", 32'(ce_a[0]), 32'd0);
        rst_a[0] = 1'b1;
        m_valid  = 1'b0;
        @(negedge clock);
        cmp("midrd oe_after", 32'(soe_a[0]), 32'd0);
        cmp("midrd ce_after", 32'(ce_a[0]), 32'd0);
        @(posedge clock);
        #1;
        rst_a[0] = 1'b0;
        access(1'b0, 32'h0000_0020, 8'h00, "reread_after_rst");

        for (int i = 0; i < 300; i++) begin
            int          sel;
            logic [18:0] wd;
            logic [31:0] a;
            bit          w;
            sel = $urandom_range(0, 5);
            wd  = (sel == 5) ? 19'h7FFFF : 19'(8 + sel);
            a   = {12'($urandom()), wd, 1'($urandom())};
            w   = ($urandom_range(0, 9) < 4);
            access(w, a, 8'($urandom()), w ? "rand_wr" : "rand_rd");
        end
        rst_a[0] = 1'b1;

        do_reset(1);
        access(1'b0, 32'h0000_0010, 8'h00, "w0_miss");
        access(1'b0, 32'h0000_0011, 8'h00, "w0_hit");
        access(1'b1, 32'h0000_0010, 8'h77, "w0_wr_hit");
        access(1'b0, 32'h0000_0010, 8'h00, "w0_rd_after_wr");
        access(1'b0, 32'h0000_0030, 8'h00, "w0_miss2");
        rst_a[1] = 1'b1;

        do_reset(2);
        access(1'b0, 32'h0000_0010, 8'h00, "w15_miss");
        access(1'b0, 32'h0000_0011, 8'h00, "w15_hit");
        access(1'b1, 32'h0000_0021, 8'h3C, "w15_wr_miss");
        access(1'b0, 32'h0000_0021, 8'h00, "w15_rd_written");
        rst_a[2] = 1'b1;

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_sram_bridge.md
# cpu_sram_bridge

Memory responder for the CPU byte bus (`address`/`in`/`out`/`we`/`ce`). It serves CPU byte reads and writes from an external 16-bit asynchronous SRAM with a programmable wait-state count. The CPU is stalled through its `ce` input while an SRAM cycle is in progress. A one-word read buffer lets a repeated access to the same 16-bit word complete without wait states. The bridge replaces the zero-latency block memory when the CPU runs on hardware.

## Interface
Parameters:
- `WAIT`, default 1 — extra SRAM access cycles beyond the first; legal range 0..15.

Ports:
- `clock` in 1 — single clock for all logic.
- `reset` in 1 — synchronous, active-high.
- `address` in 32 — CPU byte address; only `[19:0]` is decoded, and `[31:20]` is ignored.
- `we` in 1 — CPU write request.
- `out` in 8 — CPU write data.
- `in` out 8 — read data to the CPU; combinational.
- `ce` out 1 — CPU clock enable; combinational.
- `sram_a` out 19 — SRAM word address, equal to `address[19:1]`.
- `sram_di` in 16 — SRAM read data.
- `sram_do` out 16 — SRAM write data.
- `sram_oe` out 1 — output enable, active-high.
- `sram_we` out 1 — write strobe, active-high.
- `sram_ub` out 1 — upper byte lane enable, bits [15:8].
- `sram_lb` out 1 — lower byte lane enable, bits [7:0].

## Operation
- CPU contract: while `ce`=0, the CPU holds `address`, `we` and `out` stable. An access is consumed on the rising edge where `ce`=1.
- Read buffer registers:
  - `buf[15:0]`, the buffered word.
  - `tag[18:0]`, its word address.
  - `valid`.
- Hit condition: `hit = valid & (tag == address[19:1])`.
- Byte lanes: an even address uses `[7:0]` / `sram_lb`; an odd address uses `[15:8]` / `sram_ub`.
- `in` = `address[0]` ? `buf[15:8]` : `buf[7:0]`. It is valid whenever `ce`=1 and `we`=0.
- `ce` = (`state`==IDLE & `hit` & ~`we`) | (`state`==DONE).
- State machine, with a 4-bit wait counter `cnt`:
  - **IDLE**
    - Read hit: `ce`=1 and the state stays IDLE.
    - Read miss: latch `sram_a`, set `sram_oe`=1, `cnt`=`WAIT`, go to RD.
    - Write: latch `sram_a`, set `sram_do`={`out`,`out`}, drive the lane enables from `address[0]`, set `sram_we`=1, `cnt`=`WAIT`, go to WR.
  - **RD**
    - If `cnt`≠0, decrement.
    - If `cnt`==0: `buf`←`sram_di`, `tag`←`sram_a`, `valid`←1, `sram_oe`←0, go to DONE.
  - **WR**
    - If `cnt`≠0, decrement.
    - If `cnt`==0: clear `sram_we`, `sram_ub`, `sram_lb`, go to DONE.
    - If `hit` holds on entry to WR, the addressed byte of `buf` is updated with `out` (write-through). Otherwise `buf`, `tag` and `valid` are unchanged (no write-allocate).
  - **DONE**: `ce`=1 for exactly one cycle, then go to IDLE.
- All SRAM-side outputs are registered. `sram_a` and `sram_do` hold their value outside active cycles.
- `sram_oe` and `sram_we` are never high in the same cycle.

## Timing
- Reset, on the rising edge with `reset`=1:
  - `state`=IDLE, `valid`=0, `cnt`=0, `buf`=0, `tag`=0.
  - `sram_oe`=`sram_we`=`sram_ub`=`sram_lb`=0, `sram_a`=0, `sram_do`=0.
  - Resulting outputs: `ce`=0 (no hit is possible) and `in`=0.
- Read hit: 0 stall cycles; `ce`=1 in the same cycle.
- Read miss:
  - `ce`=0 for `WAIT`+2 cycles (1 IDLE cycle plus `WAIT`+1 RD cycles), then `ce`=1 in DONE.
  - `sram_oe` is high for `WAIT`+1 cycles.
  - `sram_di` is sampled on the last RD edge.
- Write:
  - `ce`=0 for `WAIT`+2 cycles, then one DONE cycle.
  - `sram_we` is high for exactly `WAIT`+1 cycles.
  - `sram_a`, `sram_do` and the lane enables are stable during the whole strobe.
- Back-to-back accesses: after DONE, a new access is evaluated in the next IDLE cycle. Minimum miss-to-miss spacing is `WAIT`+3 cycles.
- `WAIT`=0: RD and WR each last one cycle.
- Reset mid-RD or mid-WR: the strobe drops on that edge. Any partial `buf` update is discarded because `valid` is cleared. The CPU is not acknowledged.
- Address wrap: `address` 0xFFFFF maps to `sram_a`=0x7FFFF, upper lane. 0x100000 aliases to word 0.

## Test plan
- Reset, then read at 0x00010 with SRAM word 0x1234 at 0x08, `WAIT`=1 → `ce`=0 for 3 cycles, `sram_oe` high for 2 cycles, DONE `ce`=1 with `in`=0x34.
- Next read at 0x00011 → immediate `ce`=1 with `in`=0x12; `sram_oe` stays 0.
- Write 0xAB to 0x00011 → `sram_we` high for 2 cycles with `sram_a`=0x08, `sram_do`=0xABAB, `sram_ub`=1, `sram_lb`=0. A following read of 0x00011 hits and returns 0xAB.
- Write 0x55 to 0x00200 (miss), then read 0x00010 → hit returns 0x34; the buffer is not allocated.
- `WAIT`=0 read miss → `ce`=0 for 2 cycles. `WAIT`=15 → `ce`=0 for 17 cycles.
- Assert `reset` in the 2nd RD cycle → next cycle `sram_oe`=0, `ce`=0; re-reading the same address takes the full miss path.
